// File: rtl/axis_sum_trailer_inserter_pkg.sv
// Shared types and helpers for the sum-trailer AXI-Stream stage.
// Holds the FSM encoding and the byte-enable to bit-mask expansion.
package axis_sum_trailer_inserter_pkg;

   localparam int MAX_DATA_WIDTH = 256;
   localparam int MAX_KEEP_WIDTH = MAX_DATA_WIDTH / 8;

   typedef enum logic {
      S_PASS  = 1'b0,
      S_TRAIL = 1'b1
   } state_t;

   // Each tkeep bit becomes eight identical mask bits; callers truncate to their width.
   function automatic logic [MAX_DATA_WIDTH-1:0] keep_to_mask(input logic [MAX_KEEP_WIDTH-1:0] keep);
      logic [MAX_DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
         m[i*8 +: 8] = {8{keep[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_keep_masker.sv
// Combinational byte mask: zeroes every tdata byte whose tkeep bit is clear.
module axis_keep_masker
   import axis_sum_trailer_inserter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   i_tdata,
   input  logic [DATA_WIDTH/8-1:0] i_tkeep,
   output logic [DATA_WIDTH-1:0]   o_tdata
);

   assign o_tdata = DATA_WIDTH'(MAX_DATA_WIDTH'(i_tdata) & keep_to_mask(MAX_KEEP_WIDTH'(i_tkeep)));

endmodule

// File: rtl/axis_sum_trailer_inserter.sv
// Forwards packet beats and, when enabled at packet start, appends one trailer
// beat holding the modulo-2^DATA_WIDTH sum of the byte-masked payload words.
module axis_sum_trailer_inserter
   import axis_sum_trailer_inserter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_enable,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [CNT_WIDTH-1:0]    pkt_count
);

   // Handshakes: a beat transfers on a rising clk edge where tvalid and tready
   // are both high; a source holding tvalid keeps its payload stable until then.

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_in_pkt;
   logic                    r_en_pkt;
   logic [DATA_WIDTH-1:0]   r_acc;
   logic [DATA_WIDTH-1:0]   r_trailer;
   logic [DATA_WIDTH-1:0]   r_m_tdata;
   logic [KEEP_WIDTH-1:0]   r_m_tkeep;
   logic                    r_m_tvalid;
   logic                    r_m_tlast;
   logic [CNT_WIDTH-1:0]    r_pkt_count;

   logic                    w_ld;
   logic                    w_s_tready;
   logic                    w_accept;
   logic                    w_en_eff;
   logic [DATA_WIDTH-1:0]   w_masked;

   axis_keep_masker #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_keep_masker (
      .i_tdata (s_axis_tdata),
      .i_tkeep (s_axis_tkeep),
      .o_tdata (w_masked)
   );

   assign w_ld     = m_axis_tready | ~r_m_tvalid;
   assign w_accept = s_axis_tvalid & w_s_tready;
   // The first beat of a packet sees cfg_enable directly; later beats use the sampled copy.
   assign w_en_eff = r_in_pkt ? r_en_pkt : cfg_enable;

   always_comb begin
      w_state_nxt = r_state;
      w_s_tready  = 1'b0;
      case (r_state)
         S_PASS: begin
            w_s_tready = w_ld;
            if (w_accept && w_en_eff && s_axis_tlast) begin
               w_state_nxt = S_TRAIL;
            end
         end
         S_TRAIL: begin
            if (w_ld) begin
               w_state_nxt = S_PASS;
            end
         end
         default: w_state_nxt = S_PASS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_PASS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in_pkt   <= 1'b0;
         r_en_pkt   <= 1'b0;
         r_acc      <= '0;
         r_trailer  <= '0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end else if (r_state == S_PASS) begin
         if (w_accept) begin
            if (!r_in_pkt) begin
               r_en_pkt <= cfg_enable;
            end
            r_in_pkt   <= ~s_axis_tlast;
            r_m_tdata  <= s_axis_tdata;
            r_m_tkeep  <= s_axis_tkeep;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= s_axis_tlast & ~w_en_eff;
            if (w_en_eff) begin
               if (s_axis_tlast) begin
                  r_trailer <= r_acc + w_masked;
                  r_acc     <= '0;
               end else begin
                  r_acc     <= r_acc + w_masked;
               end
            end
         end else if (w_ld) begin
            r_m_tvalid <= 1'b0;
         end
      end else if (w_ld) begin
         r_m_tdata  <= r_trailer;
         r_m_tkeep  <= '1;
         r_m_tvalid <= 1'b1;
         r_m_tlast  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pkt_count <= '0;
      end else if (r_m_tvalid && m_axis_tready && r_m_tlast) begin
         r_pkt_count <= r_pkt_count + 1'b1;
      end
   end

   assign s_axis_tready = w_s_tready;
   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;
   assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_sum_trailer_inserter.sv
// Self-checking bench: packet-level model of forwarded beats plus trailer sums,
// compared every cycle against the DUT output handshake, ready and counter.
module tb_axis_sum_trailer_inserter;

   logic        clk;
   logic        rst_n;
   logic        cfg_enable;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [3:0]  s_axis_tkeep;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_tkeep;
   logic [15:0] pkt_count;

   axis_sum_trailer_inserter #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_enable    (cfg_enable),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tkeep  (s_axis_tkeep),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tkeep  (m_axis_tkeep),
      .pkt_count     (pkt_count)
   );

   // ---------------- clock / reset / state ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          bp_pct = 0;
   bit          chk_en = 0;
   bit          cur_en = 0;
   bit          trail_pending = 0;
   bit          gaps = 0;
   logic [15:0] exp_cnt = '0;
   logic [31:0] last_data = '0;
   logic [36:0] exp_q[$];
   logic [31:0] pd[$];
   logic [3:0]  pk[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] k);
      logic [31:0] r;
      r = 32'h0;
      for (int b = 0; b < 4; b++) if (k[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] pkt_sum();
      logic [31:0] s;
      s = 32'h0;
      foreach (pd[i]) s = s + masked(pd[i], pk[i]);
      return s;
   endfunction

   task automatic model_push(input bit en);
      int n;
      n = pd.size();
      for (int i = 0; i < n; i++) exp_q.push_back({pd[i], pk[i], (i == n - 1) & ~en});
      if (en) exp_q.push_back({pkt_sum(), 4'hF, 1'b1});
   endtask

   // ---------------- drivers ----------------
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = ($urandom_range(0, 99) >= bp_pct);
      end
   end

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_axis_tready && n < 300);
      if (!s_axis_tready) begin
         n_chk++;
         n_err++;
         $display("FAIL s_accept_timeout actual=0 required=1 at %0t", $time);
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   // Sends pd/pk as one packet; tog flips cfg_enable after the first beat.
   task automatic send_pkt(input bit en, input bit tog);
      model_push(en);
      cur_en     = en;
      cfg_enable = en;
      foreach (pd[i]) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         send_beat(pd[i], pk[i], i == pd.size() - 1);
         if (tog && i == 0) cfg_enable = ~en;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout actual=%0d required=0 beats pending", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard / compare ----------------
   initial begin
      logic        prev_stall;
      logic [36:0] prev_out;
      logic [36:0] cur_out;
      logic [36:0] e;
      logic        exp_rdy;
      logic        ld;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            cur_out = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            ld      = m_axis_tready | ~m_axis_tvalid;
            exp_rdy = ld & ~trail_pending;
            check("s_tready", s_axis_tready, exp_rdy);
            check("pkt_count", pkt_count, exp_cnt);
            if (prev_stall) begin
               check("stall_valid", m_axis_tvalid, 1'b1);
               check("stall_stable", cur_out, prev_out);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL extra_beat actual=%h required=none", cur_out);
               end else begin
                  e = exp_q.pop_front();
                  check("out_beat", cur_out, e);
                  if (e[0]) exp_cnt = exp_cnt + 16'd1;
                  last_data = m_axis_tdata;
               end
            end
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast && cur_en) trail_pending = 1'b1;
            else if (trail_pending && ld) trail_pending = 1'b0;
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_out   = cur_out;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      rst_n         = 1'b0;
      cfg_enable    = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tkeep  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", m_axis_tvalid, 1'b0);
      check("rst_tdata", m_axis_tdata, 32'h0);
      check("rst_tlast_keep", {m_axis_tlast, m_axis_tkeep}, 5'h0);
      check("rst_pkt_count", pkt_count, 16'h0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Model pins against hand-computed sums.
      pd = '{32'h1, 32'h2, 32'h3}; pk = '{4'hF, 4'hF, 4'hF};
      check("model_sum_123", pkt_sum(), 32'h6);
      send_pkt(1'b1, 1'b0);
      wait_drain();
      check("t1_trailer", last_data, 32'h6);
      check("t1_pkt_count", pkt_count, 16'd1);

      pd = '{32'hFFFFFFFF, 32'h00000002}; pk = '{4'hF, 4'hF};
      check("model_sum_wrap", pkt_sum(), 32'h1);
      send_pkt(1'b1, 1'b0);
      wait_drain();
      check("t2_trailer_wrap", last_data, 32'h1);

      pd = '{32'h00000001, 32'hAABBCCDD}; pk = '{4'hF, 4'h3};
      check("model_sum_keep", pkt_sum(), 32'h0000CCDE);
      send_pkt(1'b1, 1'b0);
      wait_drain();
      check("t2_trailer_keep", last_data, 32'h0000CCDE);

      // Pass-through with a mid-packet enable toggle.
      pd = '{32'h5, 32'h6}; pk = '{4'hF, 4'hF};
      send_pkt(1'b0, 1'b1);
      wait_drain();
      check("t3_last_data", last_data, 32'h6);
      check("t3_pkt_count", pkt_count, 16'd4);

      // Back-to-back single-beat packets.
      pd = '{32'h10}; pk = '{4'hF};
      send_pkt(1'b1, 1'b0);
      pd = '{32'h20}; pk = '{4'hF};
      send_pkt(1'b1, 1'b0);
      wait_drain();
      check("t5_trailer", last_data, 32'h20);
      check("t5_pkt_count", pkt_count, 16'd6);

      // Random packets under backpressure.
      bp_pct = 50;
      gaps   = 1;
      for (int p = 0; p < 20; p++) begin
         int len;
         len = $urandom_range(1, 6);
         pd.delete();
         pk.delete();
         for (int i = 0; i < len; i++) begin
            pd.push_back($urandom());
            pk.push_back(4'($urandom_range(0, 15)));
         end
         send_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_drain();
      bp_pct = 0;
      gaps   = 0;
      repeat (2) @(posedge clk);
      #1;

      // Reset after two beats of a four-beat enabled packet.
      cur_en     = 1'b1;
      cfg_enable = 1'b1;
      exp_q.push_back({32'hA1, 4'hF, 1'b0});
      exp_q.push_back({32'hA2, 4'hF, 1'b0});
      send_beat(32'hA1, 4'hF, 1'b0);
      send_beat(32'hA2, 4'hF, 1'b0);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
      check("mid_rst_tdata", m_axis_tdata, 32'h0);
      check("mid_rst_tlast_keep", {m_axis_tlast, m_axis_tkeep}, 5'h0);
      check("mid_rst_pkt_count", pkt_count, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      trail_pending = 1'b0;
      exp_cnt       = '0;
      chk_en        = 1'b1;
      pd = '{32'h7}; pk = '{4'hF};
      send_pkt(1'b1, 1'b0);
      wait_drain();
      check("t6_trailer_after_rst", last_data, 32'h7);
      check("t6_pkt_count", pkt_count, 16'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
